// File: rtl/sensor_result_arbiter.sv
// Serializes per-channel frequency-meter results onto a single valid/ready stream, with one-deep
// capture slots, round-robin grant, sticky overrun flags and a stall watchdog emitting STALE records.
module sensor_result_arbiter #(
  parameter int CHANNELS     = 2,
  parameter int DATA_BITS    = 32,
  parameter int TIMEOUT_BITS = 20,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          CLK,
  input  logic                          RESETN,
  input  logic [CHANNELS-1:0]           CHANNEL_EN,
  input  logic [CHANNELS-1:0]           EDGE_FLAG,
  input  logic [CHANNELS*DATA_BITS-1:0] DURATION,
  input  logic [TIMEOUT_BITS-1:0]       TIMEOUT_LIMIT,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic [CH_W-1:0]               OUT_CHANNEL,
  output logic [DATA_BITS-1:0]          OUT_DATA,
  output logic                          OUT_STALE,
  output logic [CHANNELS-1:0]           OVERRUN,
  input  logic [CHANNELS-1:0]           OVERRUN_CLEAR
);

  typedef enum logic {ST_IDLE, ST_PRESENT} state_e;

  state_e                  state_q, state_d;
  logic [DATA_BITS-1:0]    slot_data_q [CHANNELS];
  logic [DATA_BITS-1:0]    slot_data_d [CHANNELS];
  logic [TIMEOUT_BITS-1:0] wdog_q [CHANNELS];
  logic [TIMEOUT_BITS-1:0] wdog_d [CHANNELS];
  logic [CHANNELS-1:0]     slot_stale_q, slot_stale_d;
  logic [CHANNELS-1:0]     pending_q, pending_d;
  logic [CHANNELS-1:0]     overrun_q, overrun_d;
  logic [CH_W-1:0]         ptr_q, ptr_d;
  logic [CH_W-1:0]         out_channel_q, out_channel_d;
  logic [DATA_BITS-1:0]    out_data_q, out_data_d;
  logic                    out_stale_q, out_stale_d;

  logic                    cand_found;
  logic [CH_W-1:0]         cand_idx;
  logic                    grant;

  // Round-robin scan starting at the pointer.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    idx        = 0;
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (int'(ptr_q) + k) % CHANNELS;
      if (!cand_found && pending_q[idx]) begin
        cand_found = 1'b1;
        cand_idx   = CH_W'(idx);
      end
    end
  end

  assign grant = cand_found && ((state_q == ST_IDLE) || OUT_READY);

  // Output register and FSM; a granted record is loaded from the slot's old contents.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    out_channel_d = out_channel_q;
    out_data_d    = out_data_q;
    out_stale_d   = out_stale_q;
    if (grant) begin
      state_d       = ST_PRESENT;
      out_channel_d = cand_idx;
      out_data_d    = slot_data_q[cand_idx];
      out_stale_d   = slot_stale_q[cand_idx];
      ptr_d         = (int'(cand_idx) == CHANNELS - 1) ? '0 : cand_idx + 1'b1;
    end else if (state_q == ST_PRESENT && OUT_READY) begin
      state_d = ST_IDLE;
    end
  end

  // Per-channel capture, watchdog and overrun tracking.
  always_comb begin
    logic granted_i, expiry, new_rec, set_ovr;
    granted_i = 1'b0;
    expiry    = 1'b0;
    new_rec   = 1'b0;
    set_ovr   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      slot_data_d[i]  = slot_data_q[i];
      slot_stale_d[i] = slot_stale_q[i];
      pending_d[i]    = pending_q[i];
      wdog_d[i]       = wdog_q[i];
      granted_i = grant && (int'(cand_idx) == i);
      expiry    = (TIMEOUT_LIMIT != '0) && (wdog_q[i] == TIMEOUT_LIMIT - 1'b1);
      new_rec   = CHANNEL_EN[i] && (EDGE_FLAG[i] || expiry);
      set_ovr   = new_rec && pending_q[i] && !granted_i;
      if (granted_i) pending_d[i] = 1'b0;
      if (!CHANNEL_EN[i]) begin
        pending_d[i] = 1'b0;
        wdog_d[i]    = '0;
      end else if (new_rec) begin
        // An edge beats a simultaneous watchdog expiry.
        slot_data_d[i]  = EDGE_FLAG[i] ? DURATION[i*DATA_BITS +: DATA_BITS] : '0;
        slot_stale_d[i] = !EDGE_FLAG[i];
        pending_d[i]    = 1'b1;
        wdog_d[i]       = '0;
      end else if (wdog_q[i] != '1) begin
        wdog_d[i] = wdog_q[i] + 1'b1;
      end
      overrun_d[i] = (overrun_q[i] && !OVERRUN_CLEAR[i]) || set_ovr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      out_channel_q <= '0;
      out_data_q    <= '0;
      out_stale_q   <= 1'b0;
      slot_stale_q  <= '0;
      pending_q     <= '0;
      overrun_q     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        slot_data_q[i] <= '0;
        wdog_q[i]      <= '0;
      end
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      out_channel_q <= out_channel_d;
      out_data_q    <= out_data_d;
      out_stale_q   <= out_stale_d;
      slot_stale_q  <= slot_stale_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      for (int i = 0; i < CHANNELS; i++) begin
        slot_data_q[i] <= slot_data_d[i];
        wdog_q[i]      <= wdog_d[i];
      end
    end
  end

  assign OUT_VALID   = (state_q == ST_PRESENT);
  assign OUT_CHANNEL = out_channel_q;
  assign OUT_DATA    = out_data_q;
  assign OUT_STALE   = out_stale_q;
  assign OVERRUN     = overrun_q;

endmodule

// File: tb/tb_sensor_result_arbiter.sv
// Directed bench for sensor_result_arbiter: table of single-cycle vectors plus hand-written
// sequences for watchdog timing, channel disable and asynchronous reset.
module tb_sensor_result_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  chan_en;
  logic [1:0]  edge_flag;
  logic [63:0] duration;
  logic [19:0] timeout_limit;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_channel;
  logic [31:0] out_data;
  logic        out_stale;
  logic [1:0]  overrun;
  logic [1:0]  overrun_clear;

  int n_checks = 0;
  int n_pass   = 0;

  sensor_result_arbiter #(.CHANNELS(2), .DATA_BITS(32), .TIMEOUT_BITS(20)) dut (
    .CLK           (clk),
    .RESETN        (rst_n),
    .CHANNEL_EN    (chan_en),
    .EDGE_FLAG     (edge_flag),
    .DURATION      (duration),
    .TIMEOUT_LIMIT (timeout_limit),
    .OUT_VALID     (out_valid),
    .OUT_READY     (out_ready),
    .OUT_CHANNEL   (out_channel),
    .OUT_DATA      (out_data),
    .OUT_STALE     (out_stale),
    .OVERRUN       (overrun),
    .OVERRUN_CLEAR (overrun_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  edge_f;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        ready;
    logic [1:0]  clr;
    logic        exp_valid;
    logic        exp_ch;
    logic [31:0] exp_data;
    logic        exp_stale;
    logic [1:0]  exp_ovr;
  } vec_t;

  vec_t vecs [24];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] e, input logic [31:0] d0, input logic [31:0] d1,
                       input logic r, input logic [1:0] c);
    edge_flag     = e;
    duration      = {d1, d0};
    out_ready     = r;
    overrun_clear = c;
  endtask

  initial begin
    int bad;
    int rec_cycle [3];
    int n_rec;

    // Records: edge, d0, d1, ready, clear | valid, ch, data, stale, overrun (state after the edge)
    vecs[0]  = '{2'b11, 32'hA, 32'hB, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00};
    vecs[1]  = '{2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 1'b0, 32'hA, 1'b0, 2'b00};
    vecs[2]  = '{2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 1'b1, 32'hB, 1'b0, 2'b00};
    vecs[3]  = '{2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00};
    vecs[4]  = '{2'b11, 32'hC, 32'hD, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00};
    vecs[5]  = '{2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 1'b0, 32'hC, 1'b0, 2'b00};
    vecs[6]  = '{2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 1'b1, 32'hD, 1'b0, 2'b00};
    vecs[7]  = '{2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00};
    vecs[8]  = '{2'b01, 32'h0001_2345, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00};
    vecs[9]  = '{2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h0001_2345, 1'b0, 2'b00};
    vecs[10] = '{2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00};
    vecs[11] = '{2'b10, 32'h0, 32'h5, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00};
    vecs[12] = '{2'b10, 32'h0, 32'h6, 1'b0, 2'b00, 1'b1, 1'b1, 32'h5, 1'b0, 2'b00};
    vecs[13] = '{2'b10, 32'h0, 32'h7, 1'b0, 2'b00, 1'b1, 1'b1, 32'h5, 1'b0, 2'b10};
    vecs[14] = '{2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h5, 1'b0, 2'b10};
    vecs[15] = '{2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 1'b1, 32'h7, 1'b0, 2'b10};
    vecs[16] = '{2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b10};
    vecs[17] = '{2'b00, 32'h0, 32'h0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00};
    vecs[18] = '{2'b10, 32'h0, 32'h8, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00};
    vecs[19] = '{2'b10, 32'h0, 32'h9, 1'b0, 2'b00, 1'b1, 1'b1, 32'h8, 1'b0, 2'b00};
    vecs[20] = '{2'b10, 32'h0, 32'hA, 1'b0, 2'b10, 1'b1, 1'b1, 32'h8, 1'b0, 2'b10};
    vecs[21] = '{2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 1'b1, 32'hA, 1'b0, 2'b10};
    vecs[22] = '{2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0, 2'b10};
    vecs[23] = '{2'b00, 32'h0, 32'h0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00};

    rst_n         = 1'b0;
    chan_en       = 2'b00;
    timeout_limit = '0;
    drive(2'b00, 32'h0, 32'h0, 1'b0, 2'b00);
    step();
    step();
    check("reset_valid", 64'(out_valid), 64'h0);
    check("reset_channel", 64'(out_channel), 64'h0);
    check("reset_data", 64'(out_data), 64'h0);
    check("reset_stale", 64'(out_stale), 64'h0);
    check("reset_overrun", 64'(overrun), 64'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    chan_en = 2'b11;

    // Round-robin, latency, hold under backpressure, overrun and clear priority.
    for (int v = 0; v < 24; v++) begin
      drive(vecs[v].edge_f, vecs[v].d0, vecs[v].d1, vecs[v].ready, vecs[v].clr);
      step();
      check($sformatf("vec%0d_valid", v), 64'(out_valid), 64'(vecs[v].exp_valid));
      check($sformatf("vec%0d_overrun", v), 64'(overrun), 64'(vecs[v].exp_ovr));
      if (vecs[v].exp_valid) begin
        check($sformatf("vec%0d_channel", v), 64'(out_channel), 64'(vecs[v].exp_ch));
        check($sformatf("vec%0d_data", v), 64'(out_data), 64'(vecs[v].exp_data));
        check($sformatf("vec%0d_stale", v), 64'(out_stale), 64'(vecs[v].exp_stale));
      end
    end
    drive(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);

    // Watchdog: one disabled cycle zeroes the counter, then STALE every 100 cycles;
    // an edge coinciding with expiry at cycle 300 yields a normal record.
    chan_en = 2'b00;
    step();
    chan_en       = 2'b01;
    timeout_limit = 20'd100;
    bad   = 0;
    n_rec = 0;
    for (int cyc = 1; cyc <= 320; cyc++) begin
      drive((cyc == 300) ? 2'b01 : 2'b00, 32'h55, 32'h0, 1'b1, 2'b00);
      step();
      if (out_valid) begin
        if (n_rec < 3) rec_cycle[n_rec] = cyc;
        n_rec++;
        if (cyc == 301) begin
          check("wdog_edge_data", 64'(out_data), 64'h55);
          check("wdog_edge_stale", 64'(out_stale), 64'h0);
        end else begin
          check("wdog_stale_flag", 64'(out_stale), 64'h1);
          check("wdog_stale_data", 64'(out_data), 64'h0);
          check("wdog_stale_channel", 64'(out_channel), 64'h0);
        end
      end
    end
    check("wdog_record_count", 64'(n_rec), 64'd3);
    if (n_rec >= 3) begin
      check("wdog_first_at", 64'(rec_cycle[0]), 64'd101);
      check("wdog_second_at", 64'(rec_cycle[1]), 64'd201);
      check("wdog_edge_at", 64'(rec_cycle[2]), 64'd301);
    end
    drive(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);
    timeout_limit = '0;
    for (int cyc = 0; cyc < 250; cyc++) begin
      step();
      if (out_valid) bad++;
    end
    check("wdog_off_no_records", 64'(bad), 64'd0);

    // Channel disable drops a pending slot; edges while disabled are ignored.
    chan_en = 2'b11;
    drive(2'b01, 32'h11, 32'h0, 1'b0, 2'b00);
    step();
    check("dis_idle", 64'(out_valid), 64'h0);
    drive(2'b10, 32'h0, 32'h22, 1'b0, 2'b00);
    step();
    check("dis_ch0_valid", 64'(out_valid), 64'h1);
    check("dis_ch0_data", 64'(out_data), 64'h11);
    chan_en = 2'b01;
    drive(2'b10, 32'h0, 32'h33, 1'b0, 2'b00);
    step();
    check("dis_hold_data", 64'(out_data), 64'h11);
    chan_en = 2'b11;
    drive(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);
    step();
    check("dis_no_ch1", 64'(out_valid), 64'h0);
    bad = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      step();
      if (out_valid) bad++;
    end
    check("dis_stays_idle", 64'(bad), 64'd0);

    // Asynchronous reset while a record is presented under backpressure.
    drive(2'b01, 32'h77, 32'h0, 1'b0, 2'b00);
    step();
    drive(2'b10, 32'h0, 32'h88, 1'b0, 2'b00);
    step();
    check("rst_pre_valid", 64'(out_valid), 64'h1);
    drive(2'b00, 32'h0, 32'h0, 1'b0, 2'b00);
    rst_n = 1'b0;
    #2;
    check("rst_async_valid", 64'(out_valid), 64'h0);
    check("rst_async_data", 64'(out_data), 64'h0);
    step();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    bad = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      step();
      if (out_valid) bad++;
    end
    check("rst_slots_lost", 64'(bad), 64'd0);
    drive(2'b01, 32'h99, 32'h0, 1'b1, 2'b00);
    step();
    drive(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);
    step();
    check("rst_after_valid", 64'(out_valid), 64'h1);
    check("rst_after_data", 64'(out_data), 64'h99);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
